// File: rtl/mem_block_copier.sv
// rtl/mem_block_copier.sv - memmove-style block copier driving the word-addressed data memory bus
// One word per READ/WRITE cycle pair; direction is chosen at start so overlapping regions copy correctly.
module mem_block_copier #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [LEN_W-1:0]  Length,
  output logic              busy,
  output logic              done,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] ReadData
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_ptr, dst_ptr, src_nxt, dst_nxt;
  logic [LEN_W-1:0]  remaining, remaining_nxt;
  logic [DATA_W-1:0] data_buf, data_buf_nxt;
  logic              descending, descending_nxt;

  logic              busy_nxt, done_nxt, mem_read_nxt, mem_write_nxt;
  logic [ADDR_W-1:0] address_nxt;
  logic [DATA_W-1:0] write_data_nxt;

  logic [ADDR_W-1:0] len_ext;
  logic [ADDR_W:0]   src_end;
  logic              dst_inside_src;

  // Extra bit keeps SrcAddr+Length from wrapping when judging overlap.
  assign len_ext        = ADDR_W'(Length);
  assign src_end        = {1'b0, SrcAddr} + {1'b0, len_ext};
  assign dst_inside_src = (DstAddr > SrcAddr) && ({1'b0, DstAddr} < src_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (Length == '0) ? DONE : READ;
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = (remaining == LEN_W'(1)) ? DONE : READ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Computes the next datapath values and the next registered bus outputs.
  always_comb begin
    src_nxt        = src_ptr;
    dst_nxt        = dst_ptr;
    remaining_nxt  = remaining;
    data_buf_nxt   = data_buf;
    descending_nxt = descending;
    case (state)
      IDLE: begin
        if (start && (Length != '0)) begin
          descending_nxt = dst_inside_src;
          remaining_nxt  = Length;
          if (dst_inside_src) begin
            src_nxt = SrcAddr + len_ext - ADDR_W'(1);
            dst_nxt = DstAddr + len_ext - ADDR_W'(1);
          end else begin
            src_nxt = SrcAddr;
            dst_nxt = DstAddr;
          end
        end
      end
      READ: data_buf_nxt = ReadData;
      WRITE: begin
        remaining_nxt = remaining - LEN_W'(1);
        if (remaining != LEN_W'(1)) begin
          src_nxt = descending ? src_ptr - ADDR_W'(1) : src_ptr + ADDR_W'(1);
          dst_nxt = descending ? dst_ptr - ADDR_W'(1) : dst_ptr + ADDR_W'(1);
        end
      end
      default: ;
    endcase

    busy_nxt       = (state_nxt == READ) || (state_nxt == WRITE);
    done_nxt       = (state_nxt == DONE);
    mem_read_nxt   = (state_nxt == READ);
    mem_write_nxt  = (state_nxt == WRITE);
    address_nxt    = Address;
    write_data_nxt = WriteData;
    if (state_nxt == READ) begin
      address_nxt = src_nxt;
    end else if (state_nxt == WRITE) begin
      address_nxt    = dst_nxt;
      write_data_nxt = data_buf_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ptr    <= '0;
      dst_ptr    <= '0;
      remaining  <= '0;
      data_buf   <= '0;
      descending <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      Address    <= '0;
      WriteData  <= '0;
    end else begin
      src_ptr    <= src_nxt;
      dst_ptr    <= dst_nxt;
      remaining  <= remaining_nxt;
      data_buf   <= data_buf_nxt;
      descending <= descending_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      MemRead    <= mem_read_nxt;
      MemWrite   <= mem_write_nxt;
      Address    <= address_nxt;
      WriteData  <= write_data_nxt;
    end
  end

endmodule
